// File: rtl/seg_disp_ctrl.sv
// Seven-segment display controller: CPU/debug arbitration, double-dabble BCD conversion,
// blank mask and display enable. Define SEG_LZB_EN to enable leading-zero blanking.
module seg_disp_ctrl #(
    parameter int unsigned DATA_W   = 17,
    parameter int unsigned CPU_HOLD = 50_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] write_data,
    input  logic              digwrite,
    input  logic              digcs,
    input  logic              dbg_req,
    input  logic [DATA_W-1:0] dbg_data,
    output logic              dbg_ack,
    output logic [31:0]       num,
    output logic [7:0]        blank,
    output logic              disp_en,
    output logic              src,
    output logic              busy,
    output logic              drop
);

    localparam int unsigned BCD_W  = 32;
    localparam int unsigned CNT_W  = $clog2(DATA_W + 1);
    localparam int unsigned HOLD_W = $clog2(CPU_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pend_q, pend_d;
    logic [DATA_W-1:0]   pend_val_q, pend_val_d;
    logic                cur_src_q, cur_src_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [BCD_W-1:0]    num_q, num_d;
    logic [7:0]          blank_q, blank_d;
    logic                disp_en_q, disp_en_d;
    logic                src_q, src_d;
    logic                busy_q, busy_d;
    logic                dbg_ack_q, dbg_ack_d;
    logic                drop_q, drop_d;

    logic                cpu_wr_c;
    logic                accept_dbg_c;
    logic                last_shift_c;
    logic [7:0]          lzb_c;

    assign cpu_wr_c     = digcs & digwrite;
    assign accept_dbg_c = dbg_req && !cpu_wr_c && !pend_q && (hold_q == '0);
    assign last_shift_c = (cnt_q == CNT_W'(DATA_W - 1));

    // Double-dabble correction: nibbles of 5 or more get +3 before the shift
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

`ifdef SEG_LZB_EN
    // Digit i goes dark when it and every higher digit are zero; digit 0 always shows
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        lzb_c    = 8'h00;
        for (int i = 7; i >= 1; i--) begin
            zero_run = zero_run && (bcd_q[4*i +: 4] == 4'd0);
            lzb_c[i] = zero_run;
        end
    end
`else
    assign lzb_c = 8'h00;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cpu_wr_c || pend_q || accept_dbg_c) state_d = SHIFT;
            SHIFT:   if (last_shift_c) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        cur_src_d  = cur_src_q;
        num_d      = num_q;
        blank_d    = blank_q;
        disp_en_d  = disp_en_q;
        src_d      = src_q;
        busy_d     = busy_q;
        dbg_ack_d  = 1'b0;
        drop_d     = 1'b0;
        hold_d     = (hold_q != '0) ? hold_q - HOLD_W'(1) : hold_q;

        unique case (state_q)
            IDLE: begin
                if (cpu_wr_c || pend_q || accept_dbg_c) begin
                    bcd_d  = '0;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                    pend_d = 1'b0;
                end
                if (cpu_wr_c) begin
                    bin_d     = write_data;
                    cur_src_d = 1'b0;
                end else if (pend_q) begin
                    bin_d     = pend_val_q;
                    cur_src_d = 1'b0;
                end else if (accept_dbg_c) begin
                    bin_d     = dbg_data;
                    cur_src_d = 1'b1;
                    dbg_ack_d = 1'b1;
                end
            end
            SHIFT: begin
                {bcd_d, bin_d} = {bcd_adjust(bcd_q), bin_q} << 1;
                cnt_d          = cnt_q + CNT_W'(1);
            end
            DONE: begin
                num_d     = bcd_q;
                src_d     = cur_src_q;
                blank_d   = lzb_c;
                disp_en_d = 1'b1;
                busy_d    = 1'b0;
                if (!cur_src_q) hold_d = HOLD_W'(CPU_HOLD);
            end
            default: ;
        endcase

        // Writes arriving mid-conversion land in a one-deep buffer; overwrite flags a drop
        if (state_q != IDLE && cpu_wr_c) begin
            pend_d     = 1'b1;
            pend_val_d = write_data;
            drop_d     = pend_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            cur_src_q  <= 1'b0;
            hold_q     <= '0;
            num_q      <= '0;
            blank_q    <= 8'h00;
            disp_en_q  <= 1'b0;
            src_q      <= 1'b0;
            busy_q     <= 1'b0;
            dbg_ack_q  <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            cur_src_q  <= cur_src_d;
            hold_q     <= hold_d;
            num_q      <= num_d;
            blank_q    <= blank_d;
            disp_en_q  <= disp_en_d;
            src_q      <= src_d;
            busy_q     <= busy_d;
            dbg_ack_q  <= dbg_ack_d;
            drop_q     <= drop_d;
        end
    end

    assign num     = num_q;
    assign blank   = blank_q;
    assign disp_en = disp_en_q;
    assign src     = src_q;
    assign busy    = busy_q;
    assign dbg_ack = dbg_ack_q;
    assign drop    = drop_q;

endmodule

// File: tb/tb_seg_disp_ctrl.sv
// Directed bench for seg_disp_ctrl with a short CPU hold window.
module tb_seg_disp_ctrl;

    localparam int unsigned DATA_W   = 17;
    localparam int unsigned CPU_HOLD = 20;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] write_data;
    logic              digwrite;
    logic              digcs;
    logic              dbg_req;
    logic [DATA_W-1:0] dbg_data;
    logic              dbg_ack;
    logic [31:0]       num;
    logic [7:0]        blank;
    logic              disp_en;
    logic              src;
    logic              busy;
    logic              drop;

    int checks = 0;
    int errors = 0;

    seg_disp_ctrl #(.DATA_W(DATA_W), .CPU_HOLD(CPU_HOLD)) dut (
        .clk(clk), .rst(rst), .write_data(write_data), .digwrite(digwrite), .digcs(digcs),
        .dbg_req(dbg_req), .dbg_data(dbg_data), .dbg_ack(dbg_ack), .num(num), .blank(blank),
        .disp_en(disp_en), .src(src), .busy(busy), .drop(drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Expected blank mask depends on whether leading-zero blanking is built in
    function automatic logic [7:0] exp_blank(input logic [7:0] lzb);
`ifdef SEG_LZB_EN
        return lzb;
`else
        return (lzb == 8'h00) ? 8'h00 : 8'h00;
`endif
    endfunction

    // One-cycle CPU write; returns at the negedge after the sampling edge with drop as seen there
    task automatic cpu_write(input logic [DATA_W-1:0] v, output logic drop_seen);
        @(negedge clk);
        write_data = v;
        digcs      = 1'b1;
        digwrite   = 1'b1;
        @(negedge clk);
        digcs      = 1'b0;
        digwrite   = 1'b0;
        drop_seen  = drop;
    endtask

    // Counts negedges with busy high, bounded
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) check("busy_timeout", 32'(n), 32'd0);
    endtask

    initial begin
        int   n;
        logic d;

        rst = 1'b1; write_data = '0; digwrite = 1'b0; digcs = 1'b0;
        dbg_req = 1'b0; dbg_data = '0;
        repeat (2) @(negedge clk);
        check("rst_num", num, 32'h0);
        check("rst_blank", 32'(blank), 32'h0);
        check("rst_disp_en", 32'(disp_en), 32'd0);
        check("rst_src", 32'(src), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack", 32'(dbg_ack), 32'd0);
        check("rst_drop", 32'(drop), 32'd0);
        rst = 1'b0;

        // 12345: busy window length and packed BCD
        cpu_write(17'd12345, d);
        wait_idle(n);
        check("busy_len", 32'(n), 32'd18);
        check("num_12345", num, 32'h0001_2345);
        check("src_12345", 32'(src), 32'd0);
        check("en_12345", 32'(disp_en), 32'd1);
        check("blank_12345", 32'(blank), 32'(exp_blank(8'b1110_0000)));

        cpu_write(17'd0, d);
        wait_idle(n);
        check("num_0", num, 32'h0);
        check("blank_0", 32'(blank), 32'(exp_blank(8'b1111_1110)));

        cpu_write(17'd131071, d);
        wait_idle(n);
        check("num_max", num, 32'h0013_1071);
        check("blank_max", 32'(blank), 32'(exp_blank(8'b1100_0000)));

        // 6 buffered, 7 overwrites it
        cpu_write(17'd5, d);
        repeat (2) @(negedge clk);
        cpu_write(17'd6, d);
        check("drop_on_6", 32'(d), 32'd0);
        cpu_write(17'd7, d);
        check("drop_on_7", 32'(d), 32'd1);
        @(negedge clk);
        check("drop_pulse", 32'(drop), 32'd0);
        wait_idle(n);
        check("commit_5", num, 32'h5);
        @(negedge clk);
        check("pend_restart", 32'(busy), 32'd1);
        wait_idle(n);
        check("commit_7", num, 32'h7);

        // Let the hold counter drain, then simultaneous CPU write and debug request
        repeat (25) @(negedge clk);
        write_data = 17'd7; digcs = 1'b1; digwrite = 1'b1;
        dbg_req = 1'b1; dbg_data = 17'd9;
        @(negedge clk);
        digcs = 1'b0; digwrite = 1'b0;
        check("sim_no_ack", 32'(dbg_ack), 32'd0);
        wait_idle(n);
        check("sim_cpu_num", num, 32'h7);
        check("sim_cpu_src", 32'(src), 32'd0);
        n = 0;
        while (!dbg_ack && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("ack_delay", 32'(n), 32'd21);
        dbg_req = 1'b0;
        @(negedge clk);
        check("ack_pulse", 32'(dbg_ack), 32'd0);
        wait_idle(n);
        check("dbg_num", num, 32'h9);
        check("dbg_src", 32'(src), 32'd1);
        check("dbg_blank", 32'(blank), 32'(exp_blank(8'b1111_1110)));

        // Reset in the middle of converting 999
        repeat (25) @(negedge clk);
        cpu_write(17'd999, d);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_num", num, 32'h0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_en", 32'(disp_en), 32'd0);
        check("mid_rst_src", 32'(src), 32'd0);
        check("mid_rst_blank", 32'(blank), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("no_commit", num, 32'h0);
        cpu_write(17'd42, d);
        wait_idle(n);
        check("num_42", num, 32'h42);
        check("en_42", 32'(disp_en), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_disp_ctrl.md
# seg_disp_ctrl

Controller between the MMIO bus and the 8-digit seven-segment tube driver. It arbitrates display ownership between CPU MMIO writes and a debug requester, and converts the winning 17-bit binary value to packed BCD with a multi-cycle double-dabble sequencer. It also produces a leading-zero blank mask and a display-enable flag. The scan/segment driver consumes `num`, `blank` and `disp_en` directly.

## Interface
- `DATA_W`, 17: binary input width; the conversion takes DATA_W shift cycles.
- `CPU_HOLD`, 50_000_000: cycles after a CPU commit during which debug requests are refused.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `write_data` in DATA_W: CPU value to display.
- `digwrite` in 1: MMIO write strobe.
- `digcs` in 1: DIG chip select from memorio. A CPU write is `digcs && digwrite` sampled on a clk edge.
- `dbg_req` in 1: debug display request; held until acked.
- `dbg_data` in DATA_W: debug value; stable while `dbg_req` is high.
- `dbg_ack` out 1: one-cycle pulse; debug request accepted.
- `num` out 32: packed BCD; digit i is `num[4i+3:4i]`.
- `blank` out 8: bit i set means digit i is dark.
- `disp_en` out 1: set on the first commit, cleared only by reset.
- `src` out 1: source of the current `num`; 0 = CPU, 1 = debug.
- `busy` out 1: a conversion is in progress.
- `drop` out 1: one-cycle pulse when a buffered CPU value is overwritten.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE selects a source by priority:
  - 1. a new CPU write this cycle;
  - 2. a pending CPU value;
  - 3. `dbg_req`, only when the hold counter is 0.
- Accepting a source in IDLE:
  - load the binary shift register and clear the BCD register and shift counter;
  - record the source and go to SHIFT;
  - for a debug accept, pulse `dbg_ack` on the same edge.
- A new CPU write in IDLE while a value is pending takes priority and clears the pending flag.
- SHIFT, each cycle:
  - add 3 to every BCD nibble that is ≥5;
  - shift {bcd, bin} left by one;
  - after DATA_W shifts go to DONE.
- DONE:
  - register `num` and `src`;
  - update `blank` and set `disp_en`;
  - return to IDLE.
  - On a CPU commit, reload the hold counter to CPU_HOLD.
- A CPU write in SHIFT or DONE goes to a one-deep pending buffer. If the buffer is already full, the new value overwrites it and `drop` pulses.
- Conversions are never preempted.
- The hold counter decrements to 0 and saturates there.
- Width: DATA_W=17 gives a maximum of 131071, so digits 6–7 are always 0. The BCD register is 32 bits.

## Timing
- Accept edge E0 sets `busy`.
- Shifts occur on E1..E_DATA_W.
- Commit is on E_(DATA_W+1) (E18 by default): `num`/`blank`/`src`/`disp_en` update and `busy` falls.
- The next accept is possible at E_(DATA_W+2).
- `dbg_ack` is high only during the cycle following E0 for a debug accept. `dbg_req` is never acked while busy or while the hold counter is nonzero.
- Simultaneous CPU write and `dbg_req` in IDLE: the CPU value is served. Debug then waits for the hold counter to reach 0.
- Reset values: `num`=0, `blank`=8'h00, `disp_en`=0, `src`=0, `busy`=0, `dbg_ack`=0, `drop`=0. FSM returns to IDLE, pending is cleared, hold counter is 0.
- Reset mid-conversion aborts with no commit.

## Configuration
- `SEG_LZB_EN` defined: at commit, `blank[i]`=1 for i≥1 when digits i..7 are all zero. Digit 0 is never blanked.
- `SEG_LZB_EN` undefined: `blank` stays 8'h00; all eight digits show, including leading zeros.

## Test plan
- CPU write 12345 (digcs=digwrite=1, one cycle) → `busy` high for 18 cycles. Then `num`=32'h0001_2345, `src`=0, `disp_en`=1, and with SEG_LZB_EN `blank`=8'b1110_0000.
- CPU write 0 → `num`=0. `blank`=8'b1111_1110 with SEG_LZB_EN, 8'h00 without.
- CPU write 131071 → `num`=32'h0013_1071.
- CPU writes 5, then 6 and 7 while busy (CPU_HOLD=20):
  - `drop` pulses once, on the write of 7;
  - 6 is discarded;
  - commits are 5, then 7.
- CPU write 7 and `dbg_req` with `dbg_data`=9 in the same cycle (CPU_HOLD=20):
  - CPU 7 commits first;
  - `dbg_ack` stays low for 20 cycles after that commit, then pulses;
  - `num` becomes 9 with `src`=1.
- Assert `rst` at shift cycle 8 of a conversion of 999 → all outputs return to their reset values, no commit occurs, and a following write of 42 yields `num`=32'h42.
